// File: rtl/frame_rx_pkg.sv
// Shared types and constants for the serial frame receiver.
package frame_rx_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/frame_rx_shreg.sv
// MSB-first data shift register with bit counter; last_c flags the final data bit.
module frame_rx_shreg #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             shift,
    input  logic             sdi,
    output logic [WIDTH-1:0] shreg,
    output logic             last_c
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CNT_W-1:0] count;

    assign last_c = (count == CNT_W'(WIDTH - 1));

    // Counter restarts on every start bit and returns to 0 after the last bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], sdi};
            count <= last_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start/data/stop framing, single-entry valid/ready output.
// Optional parity bit is compiled in with `define FRAME_RX_PARITY_EN.
module serial_frame_rx
    import frame_rx_pkg::*;
#(
    parameter int unsigned WIDTH      = 5,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             sdi,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             par_err,
    output logic             overrun,
    input  logic             clr_ovr
);

`ifdef FRAME_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    rx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg;
    logic             last_c;
    logic             start_c, shift_c, latch_par_c, stop_c;
    logic             pbad;
    logic             good_c, accept_c;

    frame_rx_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .start  (start_c),
        .shift  (shift_c),
        .sdi    (sdi),
        .shreg  (shreg),
        .last_c (last_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and per-cycle strobes; every transition is gated by bit_en.
    always_comb begin
        state_d     = state_q;
        start_c     = 1'b0;
        shift_c     = 1'b0;
        latch_par_c = 1'b0;
        stop_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bit_en && (sdi != IDLE_LEVEL)) begin
                    start_c = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_en) begin
                    shift_c = 1'b1;
                    if (last_c) state_d = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_en) begin
                    latch_par_c = 1'b1;
                    state_d     = STOP;
                end
            end
            STOP: begin
                if (bit_en) begin
                    stop_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign good_c   = stop_c && (sdi == IDLE_LEVEL) && !pbad;
    assign accept_c = !dout_valid || dout_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             pbad <= 1'b0;
        else if (latch_par_c) pbad <= ((^shreg ^ sdi) != ODD_PARITY);
    end

    // Output holding register, handshake and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            busy      <= (state_d != IDLE);
            frame_err <= stop_c && (sdi != IDLE_LEVEL);
            if (good_c && accept_c) begin
                dout       <= shreg;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (good_c && !accept_c) overrun <= 1'b1;
            else if (clr_ovr)        overrun <= 1'b0;
        end
    end

`ifdef FRAME_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_err <= 1'b0;
        else      par_err <= stop_c && (sdi == IDLE_LEVEL) && pbad;
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed table, corner sequences, random frames vs model.
module tb_serial_frame_rx;

    localparam int unsigned W = 5;
`ifdef FRAME_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_en, sdi, dout_ready, clr_ovr;
    logic [W-1:0] dout;
    logic         dout_valid, busy, frame_err, par_err, overrun;

    int total = 0;
    int bad   = 0;

    serial_frame_rx #(.WIDTH(W), .ODD_PARITY(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .sdi        (sdi),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .par_err    (par_err),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         stopb;
        logic         pflip;
        int           mode;     // 0: ready low, 1: ready whole frame, 2: ready on stop bit only
        logic [W-1:0] e_dout;
        logic         e_v, e_fe, e_pe, e_ov;
    } vec_t;

    vec_t tbl[7];

    logic [W-1:0] m_dout;
    logic         m_valid, m_ovr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives start, data (MSB first), optional parity and stop bits; ends one negedge after the stop sample.
    task automatic send_frame(input logic [W-1:0] data, input logic stopb, input logic pflip,
                              input int mode, input bit gaps);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = int'(W) - 1; i >= 0; i--) bits.push_back(data[i]);
        if (PAR) bits.push_back((^data) ^ pflip);
        bits.push_back(stopb);
        for (int k = 0; k < bits.size(); k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    bit_en     = 1'b0;
                    sdi        = 1'($urandom);
                    dout_ready = (mode == 1);
                end
            end
            @(negedge clk);
            bit_en     = 1'b1;
            sdi        = bits[k];
            dout_ready = (mode == 1) || (mode == 2 && k == bits.size() - 1);
        end
        @(negedge clk);
        bit_en     = 1'b0;
        sdi        = 1'b1;
        dout_ready = 1'b0;
    endtask

    task automatic check_frame(input string nm, input logic [W-1:0] e_dout, input logic e_v,
                               input logic e_fe, input logic e_pe, input logic e_ov);
        chk({nm, ".dout"},      32'(dout),       32'(e_dout));
        chk({nm, ".valid"},     32'(dout_valid), 32'(e_v));
        chk({nm, ".frame_err"}, 32'(frame_err),  32'(e_fe));
        chk({nm, ".par_err"},   32'(par_err),    32'(e_pe));
        chk({nm, ".overrun"},   32'(overrun),    32'(e_ov));
        chk({nm, ".busy"},      32'(busy),       32'd0);
        @(negedge clk);
        chk({nm, ".fe_pulse"},  32'(frame_err),  32'd0);
        chk({nm, ".pe_pulse"},  32'(par_err),    32'd0);
    endtask

    initial begin
        logic [W-1:0] data;
        logic         stopb, pflip, good, xfer_stop;
        int           mode;
        bit           gaps;

        tbl[0] = '{5'b10110, 1'b1, 1'b0, 0, 5'b10110, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{5'b11111, 1'b0, 1'b0, 1, 5'b10110, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{5'b00001, 1'b1, 1'b0, 0, 5'b00001, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{5'b00011, 1'b1, 1'b0, 1, 5'b00011, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{5'b11000, 1'b1, 1'b0, 0, 5'b00011, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{5'b11000, 1'b1, 1'b0, 2, 5'b11000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{5'b10110, 1'b1, 1'b1, 0, 5'b11000, 1'b1, 1'b0, PAR,  1'b1};

        rst = 1'b0; bit_en = 1'b0; sdi = 1'b1; dout_ready = 1'b0; clr_ovr = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.dout",  32'(dout),       32'd0);
        chk("reset.valid", 32'(dout_valid), 32'd0);
        chk("reset.busy",  32'(busy),       32'd0);
        chk("reset.flags", 32'({frame_err, par_err, overrun}), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].data, tbl[i].stopb, tbl[i].pflip, tbl[i].mode, 1'b0);
            check_frame($sformatf("tbl%0d", i), tbl[i].e_dout, tbl[i].e_v,
                        tbl[i].e_fe, tbl[i].e_pe, tbl[i].e_ov);
        end

        // Sticky overrun clears on clr_ovr.
        @(negedge clk); clr_ovr = 1'b1;
        @(negedge clk); clr_ovr = 1'b0;
        chk("clr.overrun", 32'(overrun),    32'd0);
        chk("clr.valid",   32'(dout_valid), 32'd1);

        // Flow-through: held word accepted in the delivery cycle of the next frame.
        send_frame(5'b01010, 1'b1, 1'b0, 2, 1'b0);
        check_frame("flow", 5'b01010, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk); dout_ready = 1'b1;
        @(negedge clk); dout_ready = 1'b0;
        chk("consume.valid", 32'(dout_valid), 32'd0);
        chk("consume.dout",  32'(dout),       32'(5'b01010));

        // Reset asserted after three data bits abandons the frame.
        @(negedge clk); bit_en = 1'b1; sdi = 1'b0;
        @(negedge clk); sdi = 1'b1;
        chk("mid.busy", 32'(busy), 32'd1);
        @(negedge clk); sdi = 1'b0;
        @(negedge clk); sdi = 1'b1;
        @(negedge clk); bit_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mid.rst.dout",  32'(dout),       32'd0);
        chk("mid.rst.valid", 32'(dout_valid), 32'd0);
        chk("mid.rst.busy",  32'(busy),       32'd0);
        @(negedge clk); rst = 1'b1; bit_en = 1'b1; sdi = 1'b1;
        repeat (8) @(negedge clk);
        chk("idle.valid", 32'(dout_valid), 32'd0);
        chk("idle.busy",  32'(busy),       32'd0);
        chk("idle.flags", 32'({frame_err, par_err, overrun}), 32'd0);
        bit_en = 1'b0;

        // Random frames against a frame-level model of the output port.
        m_dout = '0; m_valid = 1'b0; m_ovr = 1'b0;
        for (int n = 0; n < 80; n++) begin
            data  = W'($urandom);
            stopb = ($urandom_range(0, 7) != 0);
            pflip = ($urandom_range(0, 5) == 0);
            mode  = int'($urandom_range(0, 2));
            gaps  = bit'($urandom_range(0, 1));

            if (mode == 1) m_valid = 1'b0;
            xfer_stop = (mode == 2) && m_valid;
            good      = stopb && !(PAR && pflip);
            if (good) begin
                if (!m_valid || xfer_stop) begin
                    m_dout  = data;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (xfer_stop) begin
                m_valid = 1'b0;
            end

            send_frame(data, stopb, pflip, mode, gaps);
            check_frame($sformatf("rnd%0d", n), m_dout, m_valid, !stopb, stopb && PAR && pflip, m_ovr);

            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                bit_en = 1'($urandom);
                sdi    = 1'b1;
            end
            @(negedge clk); bit_en = 1'b0;
            if ($urandom_range(0, 4) == 0) begin
                clr_ovr = 1'b1;
                @(negedge clk); clr_ovr = 1'b0;
                m_ovr = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
